// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential non-restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Widest operand the magnitude/negate helper supports
    localparam int unsigned DIV_MAX_W = 64;

    // Iteration counter width for an n-bit divide: $clog2(n)
    function automatic int unsigned div_cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Two's-complement conditional negate; also yields |x| when neg is the sign bit.
    // Callers zero-extend into DIV_MAX_W bits and truncate the result back.
    function automatic logic [DIV_MAX_W-1:0] div_cond_neg(input logic [DIV_MAX_W-1:0] x,
                                                          input logic neg);
        return neg ? (~x + DIV_MAX_W'(1)) : x;
    endfunction

endpackage

// File: rtl/div_addsub_step.sv
// One non-restoring iteration: shift the partial remainder in, then add or
// subtract the divisor depending on the sign of the partial remainder.
module div_addsub_step #(
    parameter int unsigned N = 32
) (
    input  logic [N:0]   p,
    input  logic         q_msb,
    input  logic [N-1:0] d,
    output logic [N:0]   p_next_c,
    output logic         q_bit_c
);

    logic [N:0] p_shift;
    logic [N:0] d_ext;

    // Sign is taken before the shift; the shifted value may wrap in N+1 bits but
    // the add/sub result always lands back in [-D, D).
    always_comb begin
        p_shift  = {p[N-1:0], q_msb};
        d_ext    = {1'b0, d};
        p_next_c = p[N] ? (p_shift + d_ext) : (p_shift - d_ext);
        q_bit_c  = ~p_next_c[N];
    end

endmodule

// File: rtl/seq_nonrestoring_divider.sv
// Multi-cycle non-restoring divider, one quotient bit per clock, start/busy/done.
// Define DIV_SIGNED_EN for two's-complement operands; unsigned otherwise.
module seq_nonrestoring_divider
    import div_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned CW = div_cnt_w(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    div_state_e    state_q;
    div_state_e    state_nxt;
    logic          load_c;
    logic          busy_nxt;
    logic          done_nxt;

    logic [N:0]    p_q;
    logic [N-1:0]  q_q;
    logic [N-1:0]  d_q;
    logic [CW-1:0] cnt_q;
    logic          dz_q;

    logic [N:0]    step_p_c;
    logic          step_qbit_c;
    logic [N-1:0]  dvd_mag_c;
    logic [N-1:0]  dvs_mag_c;
    logic [N-1:0]  rem_mag_c;
    logic [N-1:0]  quot_c;
    logic [N-1:0]  rem_c;

`ifdef DIV_SIGNED_EN
    logic          neg_q_q;
    logic          neg_r_q;

    assign dvd_mag_c = N'(div_cond_neg(DIV_MAX_W'(dividend), dividend[N-1]));
    assign dvs_mag_c = N'(div_cond_neg(DIV_MAX_W'(divisor), divisor[N-1]));
`else
    assign dvd_mag_c = dividend;
    assign dvs_mag_c = divisor;
`endif

    div_addsub_step #(.N(N)) u_step (
        .p        (p_q),
        .q_msb    (q_q[N-1]),
        .d        (d_q),
        .p_next_c (step_p_c),
        .q_bit_c  (step_qbit_c)
    );

    // Final correction: a negative partial remainder gets one divisor added back
    assign rem_mag_c = p_q[N] ? (p_q[N-1:0] + d_q) : p_q[N-1:0];

`ifdef DIV_SIGNED_EN
    assign quot_c = dz_q ? '1 : N'(div_cond_neg(DIV_MAX_W'(q_q), neg_q_q));
    assign rem_c  = N'(div_cond_neg(DIV_MAX_W'(rem_mag_c), neg_r_q));
`else
    assign quot_c = dz_q ? '1 : q_q;
    assign rem_c  = rem_mag_c;
`endif

    // State and handshake registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    // Next state; an accept in DONE chains straight into the next divide
    always_comb begin
        state_nxt = state_q;
        load_c    = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_nxt = CALC;
                    load_c    = 1'b1;
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    state_nxt = CALC;
                    load_c    = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt == CALC) || (state_nxt == FIX);
        done_nxt = (state_nxt == DONE);
    end

    // Datapath: operand capture, iteration, and result write in FIX
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            dz_q        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
`endif
        end else begin
            if (load_c) begin
                p_q   <= '0;
                q_q   <= dvd_mag_c;
                d_q   <= dvs_mag_c;
                cnt_q <= CNT_LAST;
                dz_q  <= (divisor == '0);
`ifdef DIV_SIGNED_EN
                neg_q_q <= dividend[N-1] ^ divisor[N-1];
                neg_r_q <= dividend[N-1];
`endif
            end else if (state_q == CALC) begin
                p_q   <= step_p_c;
                q_q   <= {q_q[N-2:0], step_qbit_c};
                cnt_q <= cnt_q - CW'(1);
            end
            if (state_q == FIX) begin
                quotient    <= quot_c;
                remainder   <= rem_c;
                div_by_zero <= dz_q;
            end
        end
    end

endmodule

// File: tb/tb_seq_nonrestoring_divider.sv
// Directed self-checking bench for seq_nonrestoring_divider at N=8 (signed or unsigned build).
module tb_seq_nonrestoring_divider;

    localparam int unsigned N = 8;
    localparam int NV = 13;

    logic         clk;
    logic         reset;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int checks;
    int errors;

    typedef struct {
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } vec_t;

    vec_t vecs [NV];

    seq_nonrestoring_divider #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // busy and done must never overlap
    always @(negedge clk) begin
        if (reset) check("busy_done_overlap", 32'(busy & done), 32'd0);
    end

    // Caller has start=1 and operands set; counts edges from the sampling edge.
    task automatic wait_result(input string name, input logic [7:0] eq, input logic [7:0] er,
                               input logic edz, input bit pulse);
        int  e;
        bit  seen;
        e    = 0;
        seen = 1'b0;
        @(posedge clk);
        e = 1;
        #1;
        start    = 1'b0;
        dividend = ~dividend;
        divisor  = divisor + 8'd1;
        check({name, "/busy"}, 32'(busy), 32'd1);
        while (!seen && e < 40) begin
            if (pulse && e >= 2 && e <= 7) begin
                start    = e[0];
                dividend = 8'd9;
                divisor  = 8'd3;
            end else if (pulse) begin
                start = 1'b0;
            end
            @(posedge clk);
            e++;
            #1;
            seen = done;
        end
        check({name, "/latency"}, 32'(e), 32'd10);
        check({name, "/quotient"}, 32'(quotient), 32'(eq));
        check({name, "/remainder"}, 32'(remainder), 32'(er));
        check({name, "/div_by_zero"}, 32'(div_by_zero), 32'(edz));
    endtask

    task automatic check_hold(input string name, input logic [7:0] eq, input logic [7:0] er);
        @(posedge clk);
        #1;
        check({name, "/hold_done"}, 32'(done), 32'd0);
        check({name, "/hold_busy"}, 32'(busy), 32'd0);
        check({name, "/hold_q"}, 32'(quotient), 32'(eq));
        check({name, "/hold_r"}, 32'(remainder), 32'(er));
    endtask

    initial begin
        checks = 0;
        errors = 0;

`ifdef DIV_SIGNED_EN
        vecs[0]  = '{8'd100, 8'd7,    8'd14,  8'd2,   1'b0};
        vecs[1]  = '{8'h9C,  8'd7,    8'hF2,  8'hFE,  1'b0};
        vecs[2]  = '{8'd100, 8'hF9,   8'hF2,  8'd2,   1'b0};
        vecs[3]  = '{8'h9C,  8'hF9,   8'd14,  8'hFE,  1'b0};
        vecs[4]  = '{8'h80,  8'hFF,   8'h80,  8'd0,   1'b0};
        vecs[5]  = '{8'hF9,  8'h80,   8'd0,   8'hF9,  1'b0};
        vecs[6]  = '{8'd5,   8'd0,    8'hFF,  8'd5,   1'b1};
        vecs[7]  = '{8'd9,   8'd3,    8'd3,   8'd0,   1'b0};
        vecs[8]  = '{8'd0,   8'd5,    8'd0,   8'd0,   1'b0};
        vecs[9]  = '{8'h80,  8'd7,    8'hEE,  8'hFE,  1'b0};
        vecs[10] = '{8'd127, 8'h80,   8'd0,   8'd127, 1'b0};
        vecs[11] = '{8'hFB,  8'd0,    8'hFF,  8'hFB,  1'b1};
        vecs[12] = '{8'h80,  8'd0,    8'hFF,  8'h80,  1'b1};
`else
        vecs[0]  = '{8'd100, 8'd7,    8'd14,  8'd2,   1'b0};
        vecs[1]  = '{8'd200, 8'd7,    8'd28,  8'd4,   1'b0};
        vecs[2]  = '{8'd255, 8'd1,    8'd255, 8'd0,   1'b0};
        vecs[3]  = '{8'd5,   8'd0,    8'hFF,  8'd5,   1'b1};
        vecs[4]  = '{8'd9,   8'd3,    8'd3,   8'd0,   1'b0};
        vecs[5]  = '{8'd0,   8'd5,    8'd0,   8'd0,   1'b0};
        vecs[6]  = '{8'd128, 8'd255,  8'd0,   8'd128, 1'b0};
        vecs[7]  = '{8'd156, 8'd7,    8'd22,  8'd2,   1'b0};
        vecs[8]  = '{8'd255, 8'd255,  8'd1,   8'd0,   1'b0};
        vecs[9]  = '{8'd250, 8'd16,   8'd15,  8'd10,  1'b0};
        vecs[10] = '{8'd7,   8'd128,  8'd0,   8'd7,   1'b0};
        vecs[11] = '{8'd128, 8'd1,    8'd128, 8'd0,   1'b0};
        vecs[12] = '{8'd0,   8'd0,    8'hFF,  8'd0,   1'b1};
`endif

        reset    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset/busy", 32'(busy), 32'd0);
        check("reset/done", 32'(done), 32'd0);
        check("reset/quotient", 32'(quotient), 32'd0);
        check("reset/remainder", 32'(remainder), 32'd0);
        check("reset/div_by_zero", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            dividend = vecs[i].dvd;
            divisor  = vecs[i].dvs;
            start    = 1'b1;
            wait_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].dz, 1'b0);
            check_hold($sformatf("vec%0d", i), vecs[i].q, vecs[i].r);
        end

        // start pulses while busy must not disturb the running divide
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        wait_result("busy_pulses", 8'd14, 8'd2, 1'b0, 1'b1);
        check_hold("busy_pulses", 8'd14, 8'd2);

        // start held in the DONE cycle launches the next divide back-to-back
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        wait_result("b2b_first", 8'd14, 8'd2, 1'b0, 1'b0);
        dividend = 8'd50;
        divisor  = 8'd6;
        start    = 1'b1;
        wait_result("b2b_second", 8'd8, 8'd2, 1'b0, 1'b0);
        check_hold("b2b_second", 8'd8, 8'd2);

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midreset/busy", 32'(busy), 32'd0);
        check("midreset/done", 32'(done), 32'd0);
        check("midreset/quotient", 32'(quotient), 32'd0);
        check("midreset/remainder", 32'(remainder), 32'd0);
        check("midreset/div_by_zero", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset/idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        dividend = 8'd50;
        divisor  = 8'd6;
        start    = 1'b1;
        wait_result("after_reset", 8'd8, 8'd2, 1'b0, 1'b0);
        check_hold("after_reset", 8'd8, 8'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
